// File: rtl/write_pair_arbiter.sv
// Round-robin arbiter that pushes one (address, data) word pair per grant into a shared write FIFO.
// Optional per-core grant counters are built when WR_ARB_STATS_EN is defined.
module write_pair_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    FF_full,
  output logic                    FF_write,
  output logic [31:0]             FF_data,
  output logic                    busy,
  output logic [31:0]             pair_count
`ifdef WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH_ADDR = 2'd1,
    PUSH_DATA = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [31:0]        addr_q_reg;
  logic [31:0]        data_q_reg;
  logic [31:0]        pair_count_reg;

  logic [31:0]        addr_arr [NUM_REQ];
  logic [31:0]        data_arr [NUM_REQ];

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [2*NUM_REQ-1:0] valid_shift;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [PTR_W-1:0]     win_off;
  logic [PTR_W:0]       win_sum;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic                 grant_ok;
  logic                 grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[32*gi +: 32];
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    valid_dbl   = {req_valid, req_valid};
    valid_shift = valid_dbl >> rr_ptr_reg;
    valid_rot   = valid_shift[NUM_REQ-1:0];
    win_off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) win_off = PTR_W'(k);
    end
    win_sum = {1'b0, rr_ptr_reg} + {1'b0, win_off};
    if (win_sum >= (PTR_W+1)'(NUM_REQ)) win_sum = win_sum - (PTR_W+1)'(NUM_REQ);
    winner = win_sum[PTR_W-1:0];
    if (winner == PTR_W'(NUM_REQ - 1)) rr_ptr_next = '0;
    else                               rr_ptr_next = winner + 1'b1;
  end

  assign grant_ok = (state_reg == IDLE) || ((state_reg == PUSH_DATA) && !FF_full);
  assign grant    = grant_ok && (|req_valid);

  // Ready is masked by rst_n so the handshake is silent while reset is held.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant && rst_n && (winner == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      addr_q_reg     <= '0;
      data_q_reg     <= '0;
      pair_count_reg <= '0;
    end else begin
      if (grant) begin
        addr_q_reg <= addr_arr[winner];
        data_q_reg <= data_arr[winner];
        rr_ptr_reg <= rr_ptr_next;
      end
      case (state_reg)
        IDLE: begin
          if (grant) state_reg <= PUSH_ADDR;
        end
        PUSH_ADDR: begin
          if (!FF_full) state_reg <= PUSH_DATA;
        end
        PUSH_DATA: begin
          if (!FF_full) begin
            pair_count_reg <= pair_count_reg + 32'd1;
            state_reg      <= grant ? PUSH_ADDR : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_reg)
      PUSH_ADDR: FF_data = addr_q_reg;
      PUSH_DATA: FF_data = data_q_reg;
      default:   FF_data = 32'd0;
    endcase
  end

  assign FF_write   = (state_reg != IDLE) && !FF_full;
  assign busy       = (state_reg != IDLE);
  assign pair_count = pair_count_reg;

`ifdef WR_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt_reg <= '0;
        else if (req_ready[gi]) cnt_reg <= cnt_reg + 1'b1;
      end
      assign grant_cnt[CNT_W*gi +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_write_pair_arbiter.sv
// Bench for write_pair_arbiter: directed vector table, reset-mid-pair sequence, and a
// randomized run against a word-queue reference model.
module tb_write_pair_arbiter;

  localparam int N   = 4;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            FF_full = 1'b0;
  logic            FF_write;
  logic [31:0]     FF_data;
  logic            busy;
  logic [31:0]     pair_count;
`ifdef WR_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  write_pair_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .FF_full(FF_full), .FF_write(FF_write),
    .FF_data(FF_data), .busy(busy), .pair_count(pair_count)
`ifdef WR_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return (i == 0) ? 32'h0100_0010 : (32'h0010_0000 * i + 32'h40);
  endfunction
  function automatic logic [31:0] data_of(input int i);
    return (i == 0) ? 32'hAABB_CCDD : (32'h1111_1111 * i);
  endfunction

  typedef struct {
    bit          do_rst;
    logic [N-1:0] valid;
    logic        full;
    logic [N-1:0] rdy;
    logic        wr;
    logic [31:0] data;
    logic        bsy;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(bit r, logic [N-1:0] v, logic f, logic [N-1:0] rd,
                              logic w, logic [31:0] d, logic b, logic [31:0] p);
    vec_t t;
    t.do_rst = r; t.valid = v; t.full = f; t.rdy = rd;
    t.wr = w; t.data = d; t.bsy = b; t.pc = p;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; FF_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: words still owed to the FIFO for the granted pair.
  logic [31:0] wq[$];
  int          m_ptr;
  logic [31:0] m_pc;
  int          m_gcnt [N];

  initial begin
    vec_t vt[35];
    int nv;

    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = addr_of(i);
      req_data[32*i +: 32] = data_of(i);
    end

    // Reset state
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_write", FF_write, 0);
    chk("rst_data", FF_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pair_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    nv = 0;
    // Single request, then a second with stalls in both push phases
    vt[nv++] = mk(0, 4'b0001, 0, 4'b0001, 0, 32'h0,     0, 0);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, addr_of(0), 1, 0);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, data_of(0), 1, 0);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 0, 32'h0,     0, 1);
    vt[nv++] = mk(0, 4'b0001, 0, 4'b0001, 0, 32'h0,     0, 1);
    vt[nv++] = mk(0, 4'b0000, 1, 4'b0000, 0, addr_of(0), 1, 1);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, addr_of(0), 1, 1);
    for (int k = 0; k < 5; k++)
      vt[nv++] = mk(0, 4'b0001, 1, 4'b0000, 0, data_of(0), 1, 1);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, data_of(0), 1, 1);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 0, 32'h0,     0, 2);
    // All four requesting from rr_ptr=0, then rr_ptr=3 with cores 1 and 2
    vt[nv++] = mk(1, 4'b1111, 0, 4'b0001, 0, 32'h0,     0, 0);
    vt[nv++] = mk(0, 4'b1110, 0, 4'b0000, 1, addr_of(0), 1, 0);
    vt[nv++] = mk(0, 4'b1110, 0, 4'b0010, 1, data_of(0), 1, 0);
    vt[nv++] = mk(0, 4'b1101, 0, 4'b0000, 1, addr_of(1), 1, 1);
    vt[nv++] = mk(0, 4'b1101, 0, 4'b0100, 1, data_of(1), 1, 1);
    vt[nv++] = mk(0, 4'b1011, 0, 4'b0000, 1, addr_of(2), 1, 2);
    vt[nv++] = mk(0, 4'b1011, 0, 4'b1000, 1, data_of(2), 1, 2);
    vt[nv++] = mk(0, 4'b0111, 0, 4'b0000, 1, addr_of(3), 1, 3);
    vt[nv++] = mk(0, 4'b0111, 0, 4'b0001, 1, data_of(3), 1, 3);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, addr_of(0), 1, 4);
    vt[nv++] = mk(0, 4'b0100, 0, 4'b0100, 1, data_of(0), 1, 4);
    vt[nv++] = mk(0, 4'b0110, 0, 4'b0000, 1, addr_of(2), 1, 5);
    vt[nv++] = mk(0, 4'b0110, 0, 4'b0010, 1, data_of(2), 1, 5);
    vt[nv++] = mk(0, 4'b0100, 0, 4'b0000, 1, addr_of(1), 1, 6);
    vt[nv++] = mk(0, 4'b0100, 0, 4'b0100, 1, data_of(1), 1, 6);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, addr_of(2), 1, 7);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, data_of(2), 1, 7);
    vt[nv++] = mk(0, 4'b1001, 0, 4'b1000, 0, 32'h0,     0, 8);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, addr_of(3), 1, 8);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 1, data_of(3), 1, 8);
    vt[nv++] = mk(0, 4'b0000, 0, 4'b0000, 0, 32'h0,     0, 9);

    for (int i = 0; i < nv; i++) begin
      if (vt[i].do_rst) do_reset();
      @(negedge clk);
      req_valid = vt[i].valid;
      FF_full   = vt[i].full;
      #1;
      $display("vec %0d: valid=%b full=%b ready=%b write=%b data=%h busy=%b pc=%0d",
               i, req_valid, FF_full, req_ready, FF_write, FF_data, busy, pair_count);
      chk($sformatf("vec%0d_ready", i), req_ready, vt[i].rdy);
      chk($sformatf("vec%0d_write", i), FF_write, vt[i].wr);
      chk($sformatf("vec%0d_data", i), FF_data, vt[i].data);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("vec%0d_pc", i), pair_count, vt[i].pc);
    end

    // Reset asserted while the second pair is in its data phase
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 4'b0001;
    end
    @(negedge clk);
    #1;
    chk("pre_rst_data", FF_data, data_of(0));
    chk("pre_rst_pc", pair_count, 1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-pair: ready=%b write=%b data=%h busy=%b pc=%0d",
             req_ready, FF_write, FF_data, busy, pair_count);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_write", FF_write, 0);
    chk("midrst_data", FF_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", pair_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("postrst_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("postrst_addr", FF_data, addr_of(2));
    chk("postrst_write", FF_write, 1);

    // Randomized run against the queue model
    do_reset();
    wq.delete();
    m_ptr = 0;
    m_pc  = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit          can_grant;
      int          win;
      logic [N-1:0] e_rdy;
      logic        e_wr;
      logic [31:0] e_data;
      logic [31:0] gaddr, gdata;
      @(negedge clk);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      FF_full   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        req_addr[32*i +: 32] = $urandom;
        req_data[32*i +: 32] = $urandom;
      end
      #1;
      can_grant = (wq.size() == 0) || (wq.size() == 1 && !FF_full);
      win = -1;
      if (can_grant)
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      e_rdy  = (win >= 0) ? N'(1 << win) : '0;
      e_wr   = (wq.size() > 0) && !FF_full;
      e_data = (wq.size() > 0) ? wq[0] : 32'h0;
      chk($sformatf("rnd%0d_ready", cyc), req_ready, e_rdy);
      chk($sformatf("rnd%0d_write", cyc), FF_write, e_wr);
      chk($sformatf("rnd%0d_data", cyc), FF_data, e_data);
      chk($sformatf("rnd%0d_busy", cyc), busy, wq.size() > 0);
      chk($sformatf("rnd%0d_pc", cyc), pair_count, m_pc);
`ifdef WR_ARB_STATS_EN
      for (int i = 0; i < N; i++)
        chk($sformatf("rnd%0d_gcnt%0d", cyc, i), grant_cnt[CW*i +: CW], CW'(m_gcnt[i]));
`endif
      if (e_wr) begin
        if (wq.size() == 1) m_pc = m_pc + 1;
        void'(wq.pop_front());
      end
      if (win >= 0) begin
        gaddr = req_addr[32*win +: 32];
        gdata = req_data[32*win +: 32];
        $display("rnd %0d: grant core %0d addr=%h data=%h", cyc, win, gaddr, gdata);
        wq.push_back(gaddr);
        wq.push_back(gdata);
        m_ptr = (win + 1) % N;
        m_gcnt[win]++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
